// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter: transfer size encodings,
// default bus widths, FSM state codes and a constant-foldable clog2.
package sram_like_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order channel-ID FIFO; head is readable combinationally, push is dropped
// when full and pop is dropped when empty. Pointers wrap modulo DEPTH.
module sram_like_arbiter_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_dat_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges NUM_CH sram-like masters onto one slave port with zero added latency
// on request and response paths; s_req drops while DEPTH responses are outstanding.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic [NUM_CH-1:0]          ch_req_i,
    input  logic [NUM_CH-1:0]          ch_wr_i,
    input  logic [2*NUM_CH-1:0]        ch_size_i,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
    output logic [NUM_CH-1:0]          ch_addr_ok_o,
    output logic [NUM_CH-1:0]          ch_data_ok_o,
    output logic [DATA_W-1:0]          ch_rdata_o,
    output logic                       s_req_o,
    output logic                       s_wr_o,
    output logic [1:0]                 s_size_o,
    output logic [DATA_W/8-1:0]        s_wstrb_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    input  logic                       s_addr_ok_i,
    input  logic                       s_data_ok_i,
    input  logic [DATA_W-1:0]          s_rdata_i
);
    localparam int IDW = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam int SW  = DATA_W / 8;
    localparam int CW  = clog2(DEPTH) + 1;

    logic           state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] win, grant, head_id;
    logic           any_req, handshake, pop;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  unused_fifo_cnt;

    assign any_req = |ch_req_i;

    always_comb begin : pick_winner
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        win   = last_q;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_req_i[i]) win = IDW'(i);
            end
        end else begin
            // Search starts just past the last completed grant and wraps.
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (int'(last_q) + k) % NUM_CH;
                if (!found && ch_req_i[idx]) begin
                    found = 1'b1;
                    win   = IDW'(idx);
                end
            end
        end
    end

    assign grant     = (state_q == ST_HOLD) ? grant_q : win;
    assign s_req_o   = resetn_i & ((state_q == ST_HOLD) | (any_req & ~fifo_full));
    assign handshake = s_req_o & s_addr_ok_i;
    assign pop       = resetn_i & s_data_ok_i & ~fifo_empty;

    always_comb begin
        ch_addr_ok_o = '0;
        ch_data_ok_o = '0;
        if (handshake) ch_addr_ok_o[grant] = 1'b1;
        if (pop)       ch_data_ok_o[head_id] = 1'b1;
    end

    assign ch_rdata_o = s_rdata_i;

    always_comb begin
        s_wr_o    = 1'b0;
        s_size_o  = '0;
        s_wstrb_o = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (s_req_o) begin
            s_wr_o    = ch_wr_i[grant];
            s_size_o  = ch_size_i[int'(grant)*2 +: 2];
            s_wstrb_o = ch_wstrb_i[int'(grant)*SW +: SW];
            s_addr_o  = ch_addr_i[int'(grant)*ADDR_W +: ADDR_W];
            s_wdata_o = ch_wdata_i[int'(grant)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = handshake ? grant : last_q;
        if (state_q == ST_IDLE) begin
            if (s_req_o && !s_addr_ok_i) begin
                state_d = ST_HOLD;
                grant_d = win;
            end
        end else if (s_addr_ok_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    sram_like_arbiter_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .push_i     (handshake),
        .push_dat_i (grant),
        .pop_i      (pop),
        .head_o     (head_id),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (unused_fifo_cnt)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: one fixed-priority and one round-robin
// instance, each with a queue of expected response channels.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int DEP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    logic [NCH-1:0]    f_ch_req, f_ch_wr, f_ch_addr_ok, f_ch_data_ok;
    logic [2*NCH-1:0]  f_ch_size;
    logic [NCH*SW-1:0] f_ch_wstrb;
    logic [NCH*AW-1:0] f_ch_addr;
    logic [NCH*DW-1:0] f_ch_wdata;
    logic [DW-1:0]     f_ch_rdata, f_s_wdata, f_s_rdata;
    logic              f_s_req, f_s_wr, f_s_addr_ok, f_s_data_ok;
    logic [1:0]        f_s_size;
    logic [SW-1:0]     f_s_wstrb;
    logic [AW-1:0]     f_s_addr;

    logic [NCH-1:0]    r_ch_req, r_ch_wr, r_ch_addr_ok, r_ch_data_ok;
    logic [2*NCH-1:0]  r_ch_size;
    logic [NCH*SW-1:0] r_ch_wstrb;
    logic [NCH*AW-1:0] r_ch_addr;
    logic [NCH*DW-1:0] r_ch_wdata;
    logic [DW-1:0]     r_ch_rdata, r_s_wdata, r_s_rdata;
    logic              r_s_req, r_s_wr, r_s_addr_ok, r_s_data_ok;
    logic [1:0]        r_s_size;
    logic [SW-1:0]     r_s_wstrb;
    logic [AW-1:0]     r_s_addr;

    sram_like_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ARB_MODE(0)) u_fix (
        .clk_i(clk), .resetn_i(resetn),
        .ch_req_i(f_ch_req), .ch_wr_i(f_ch_wr), .ch_size_i(f_ch_size), .ch_wstrb_i(f_ch_wstrb),
        .ch_addr_i(f_ch_addr), .ch_wdata_i(f_ch_wdata),
        .ch_addr_ok_o(f_ch_addr_ok), .ch_data_ok_o(f_ch_data_ok), .ch_rdata_o(f_ch_rdata),
        .s_req_o(f_s_req), .s_wr_o(f_s_wr), .s_size_o(f_s_size), .s_wstrb_o(f_s_wstrb),
        .s_addr_o(f_s_addr), .s_wdata_o(f_s_wdata),
        .s_addr_ok_i(f_s_addr_ok), .s_data_ok_i(f_s_data_ok), .s_rdata_i(f_s_rdata)
    );

    sram_like_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ARB_MODE(1)) u_rr (
        .clk_i(clk), .resetn_i(resetn),
        .ch_req_i(r_ch_req), .ch_wr_i(r_ch_wr), .ch_size_i(r_ch_size), .ch_wstrb_i(r_ch_wstrb),
        .ch_addr_i(r_ch_addr), .ch_wdata_i(r_ch_wdata),
        .ch_addr_ok_o(r_ch_addr_ok), .ch_data_ok_o(r_ch_data_ok), .ch_rdata_o(r_ch_rdata),
        .s_req_o(r_s_req), .s_wr_o(r_s_wr), .s_size_o(r_s_size), .s_wstrb_o(r_s_wstrb),
        .s_addr_o(r_s_addr), .s_wdata_o(r_s_wdata),
        .s_addr_ok_i(r_s_addr_ok), .s_data_ok_i(r_s_data_ok), .s_rdata_i(r_s_rdata)
    );

    int tests = 0;
    int fails = 0;
    int fq[$];
    int rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] onehot(input int c);
        return (c < 0) ? 32'd0 : (32'd1 << c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic f_pop_chk(input string tag);
        int e;
        e = -1;
        if (fq.size() != 0) e = fq.pop_front();
        chk({tag, "_dok"}, 32'(f_ch_data_ok), onehot(e));
        chk({tag, "_rdata"}, f_ch_rdata, f_s_rdata);
    endtask

    task automatic r_pop_chk(input string tag);
        int e;
        e = -1;
        if (rq.size() != 0) e = rq.pop_front();
        chk({tag, "_dok"}, 32'(r_ch_data_ok), onehot(e));
        chk({tag, "_rdata"}, r_ch_rdata, r_s_rdata);
    endtask

    task automatic f_resp(input string tag, input logic [DW-1:0] d);
        f_s_data_ok = 1'b1;
        f_s_rdata   = d;
        @(negedge clk);
        f_pop_chk(tag);
        tick();
        f_s_data_ok = 1'b0;
    endtask

    task automatic r_resp(input string tag, input logic [DW-1:0] d);
        r_s_data_ok = 1'b1;
        r_s_rdata   = d;
        @(negedge clk);
        r_pop_chk(tag);
        tick();
        r_s_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed_time=%0t required_finish_before=100000", $time);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int last;
        logic [15:0] pat;

        resetn = 1'b0;
        f_ch_req = '0; f_ch_wr = '0; f_ch_size = {SIZE_H, SIZE_W}; f_ch_wstrb = '0;
        f_ch_addr = '0; f_ch_wdata = '0; f_s_addr_ok = 1'b1; f_s_data_ok = 1'b1; f_s_rdata = '0;
        r_ch_req = '0; r_ch_wr = '0; r_ch_size = {SIZE_B, SIZE_B}; r_ch_wstrb = '0;
        r_ch_addr = '0; r_ch_wdata = '0; r_s_addr_ok = 1'b0; r_s_data_ok = 1'b0; r_s_rdata = '0;

        // Reset: requests present but everything must stay quiet.
        f_ch_req = 2'b11;
        tick();
        tick();
        @(negedge clk);
        chk("rst_sreq", 32'(f_s_req), 32'd0);
        chk("rst_aok", 32'(f_ch_addr_ok), 32'd0);
        chk("rst_dok", 32'(f_ch_data_ok), 32'd0);
        chk("rst_saddr", f_s_addr, 32'd0);
        chk("rst_rr_sreq", 32'(r_s_req), 32'd0);
        tick();
        resetn = 1'b1;
        f_ch_req = '0; f_s_addr_ok = 1'b0; f_s_data_ok = 1'b0;
        @(negedge clk);
        chk("post_rst_sreq", 32'(f_s_req), 32'd0);
        tick();

        // Single read on channel 0, response two cycles later.
        f_ch_req = 2'b01;
        f_ch_addr[0 +: AW] = 32'h1C00_0000;
        f_s_addr_ok = 1'b1;
        @(negedge clk);
        chk("t1_sreq", 32'(f_s_req), 32'd1);
        chk("t1_saddr", f_s_addr, 32'h1C00_0000);
        chk("t1_swr", 32'(f_s_wr), 32'd0);
        chk("t1_ssize", 32'(f_s_size), 32'(SIZE_W));
        chk("t1_aok", 32'(f_ch_addr_ok), 32'd1);
        fq.push_back(0);
        tick();
        f_ch_req = '0; f_s_addr_ok = 1'b0;
        @(negedge clk);
        chk("t1_gap_dok", 32'(f_ch_data_ok), 32'd0);
        chk("t1_gap_sreq", 32'(f_s_req), 32'd0);
        tick();
        f_resp("t1_resp", 32'hDEAD_BEEF);

        // Fixed-priority collision: ch1 (write) first, ch0 next with a same-cycle response.
        f_ch_req = 2'b11;
        f_ch_wr = 2'b10;
        f_ch_addr[0 +: AW] = 32'hA000_0000;
        f_ch_addr[AW +: AW] = 32'hA100_0004;
        f_ch_wstrb[SW +: SW] = 4'hC;
        f_ch_wdata[DW +: DW] = 32'hCAFE_F00D;
        f_s_addr_ok = 1'b1;
        @(negedge clk);
        chk("t2_aok1", 32'(f_ch_addr_ok), 32'd2);
        chk("t2_saddr1", f_s_addr, 32'hA100_0004);
        chk("t2_swr1", 32'(f_s_wr), 32'd1);
        chk("t2_ssize1", 32'(f_s_size), 32'(SIZE_H));
        chk("t2_swstrb1", 32'(f_s_wstrb), 32'hC);
        chk("t2_swdata1", f_s_wdata, 32'hCAFE_F00D);
        fq.push_back(1);
        tick();
        f_ch_req = 2'b01;
        f_ch_wr = '0;
        f_s_data_ok = 1'b1;
        f_s_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("t2_aok0", 32'(f_ch_addr_ok), 32'd1);
        chk("t2_saddr0", f_s_addr, 32'hA000_0000);
        f_pop_chk("t2_resp1");
        fq.push_back(0);
        tick();
        f_ch_req = '0; f_s_addr_ok = 1'b0; f_s_data_ok = 1'b0;
        f_resp("t2_resp0", 32'h2222_2222);

        // Backpressure: ch0 held for three cycles while ch1 also requests.
        f_ch_req = 2'b01;
        f_ch_addr[0 +: AW] = 32'hB000_0000;
        f_ch_addr[AW +: AW] = 32'hB100_0000;
        @(negedge clk);
        chk("t4_sreq", 32'(f_s_req), 32'd1);
        chk("t4_saddr_c0", f_s_addr, 32'hB000_0000);
        chk("t4_aok_c0", 32'(f_ch_addr_ok), 32'd0);
        tick();
        f_ch_req = 2'b11;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk("t4_hold_saddr", f_s_addr, 32'hB000_0000);
            chk("t4_hold_aok", 32'(f_ch_addr_ok), 32'd0);
            tick();
        end
        f_s_addr_ok = 1'b1;
        @(negedge clk);
        chk("t4_aok_hs0", 32'(f_ch_addr_ok), 32'd1);
        chk("t4_saddr_hs0", f_s_addr, 32'hB000_0000);
        fq.push_back(0);
        tick();
        f_ch_req = 2'b10;
        @(negedge clk);
        chk("t4_aok_hs1", 32'(f_ch_addr_ok), 32'd2);
        chk("t4_saddr_hs1", f_s_addr, 32'hB100_0000);
        fq.push_back(1);
        tick();
        f_ch_req = '0; f_s_addr_ok = 1'b0;
        f_resp("t4_resp0", 32'h3333_3333);
        f_resp("t4_resp1", 32'h4444_4444);

        // Full FIFO and pointer wrap over 16 transactions with mixed channel IDs.
        pat = 16'hB274;
        for (int i = 0; i < 16; i++) begin
            c = int'(pat[i]);
            f_ch_req = '0;
            f_ch_req[c] = 1'b1;
            f_ch_addr[c*AW +: AW] = 32'h2000_0000 + 32'(i) * 16;
            f_s_addr_ok = 1'b1;
            if (fq.size() == DEP) begin
                if (i == DEP) begin
                    @(negedge clk);
                    chk("t5_full_stall_sreq", 32'(f_s_req), 32'd0);
                    chk("t5_full_stall_aok", 32'(f_ch_addr_ok), 32'd0);
                    tick();
                end
                f_s_data_ok = 1'b1;
                f_s_rdata = 32'h5000_0000 + 32'(i);
                @(negedge clk);
                chk("t5_full_sreq", 32'(f_s_req), 32'd0);
                chk("t5_full_aok", 32'(f_ch_addr_ok), 32'd0);
                f_pop_chk("t5_resp");
                tick();
                f_s_data_ok = 1'b0;
            end
            @(negedge clk);
            chk("t5_aok", 32'(f_ch_addr_ok), onehot(c));
            chk("t5_saddr", f_s_addr, 32'h2000_0000 + 32'(i) * 16);
            fq.push_back(c);
            tick();
        end
        f_ch_req = '0; f_s_addr_ok = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            f_resp("t5_drain", 32'h5500_0000 + 32'(i));
        end

        // Reset with two transactions outstanding.
        f_ch_req = 2'b01;
        f_ch_addr[0 +: AW] = 32'hC000_0000;
        f_s_addr_ok = 1'b1;
        @(negedge clk);
        chk("t6_aok0", 32'(f_ch_addr_ok), 32'd1);
        tick();
        f_ch_req = 2'b10;
        f_ch_addr[AW +: AW] = 32'hC100_0000;
        @(negedge clk);
        chk("t6_aok1", 32'(f_ch_addr_ok), 32'd2);
        tick();
        f_ch_req = '0; f_s_addr_ok = 1'b0;
        resetn = 1'b0;
        f_s_data_ok = 1'b1;
        f_s_rdata = '0;
        @(negedge clk);
        chk("t6_rst_sreq", 32'(f_s_req), 32'd0);
        chk("t6_rst_aok", 32'(f_ch_addr_ok), 32'd0);
        chk("t6_rst_dok", 32'(f_ch_data_ok), 32'd0);
        chk("t6_rst_saddr", f_s_addr, 32'd0);
        chk("t6_rst_swr", 32'(f_s_wr), 32'd0);
        chk("t6_rst_rdata", f_ch_rdata, 32'd0);
        tick();
        resetn = 1'b1;
        fq.delete();
        @(negedge clk);
        f_pop_chk("t6_stray");
        tick();
        f_s_data_ok = 1'b0;
        f_ch_req = 2'b01;
        f_s_addr_ok = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            f_ch_addr[0 +: AW] = 32'hC200_0000 + 32'(i);
            @(negedge clk);
            chk("t6_refill_aok", 32'(f_ch_addr_ok), 32'd1);
            fq.push_back(0);
            tick();
        end
        @(negedge clk);
        chk("t6_refill_full", 32'(f_s_req), 32'd0);
        tick();
        f_ch_req = '0; f_s_addr_ok = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            f_resp("t6_drain", 32'h6600_0000 + 32'(i));
        end

        // Round-robin: both channels request continuously, then only ch1, then both.
        r_ch_addr[0 +: AW] = 32'hD000_0000;
        r_ch_addr[AW +: AW] = 32'hD100_0000;
        r_s_addr_ok = 1'b1;
        last = NCH - 1;
        for (int i = 0; i < 8; i++) begin
            r_ch_req = (i == 6) ? 2'b10 : 2'b11;
            if (r_ch_req == 2'b11) c = 1 - last;
            else c = r_ch_req[1] ? 1 : 0;
            r_s_data_ok = (rq.size() != 0);
            r_s_rdata = 32'h7000_0000 + 32'(i);
            @(negedge clk);
            if (i > 0) r_pop_chk("rr_resp");
            chk("rr_grant", 32'(r_ch_addr_ok), onehot(c));
            chk("rr_saddr", r_s_addr, (c == 0) ? 32'hD000_0000 : 32'hD100_0000);
            chk("rr_ssize", 32'(r_s_size), 32'(SIZE_B));
            rq.push_back(c);
            last = c;
            tick();
        end
        r_ch_req = '0; r_s_addr_ok = 1'b0; r_s_data_ok = 1'b0;
        while (rq.size() != 0) begin
            r_resp("rr_drain", 32'h7700_0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
